// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one single-port SRAM between two requesters, A and B.
// - The grant is combinational: x_ready rises in the same cycle as x_valid
//   when x wins.
// - Under contention the last-granted requester keeps the port for up to
//   MAX_BURST consecutive grants. The port then passes to the other requester.
// - Any cycle without a grant clears the run count.
// - A read returns its data exactly one cycle after the grant, on x_rvalid and
//   x_rdata. A write gets no response.
//
// Ports
//   clk                      single clock, rising edge
//   rst                      asynchronous reset, active low
//   a_valid/a_write/a_addr/a_wdata   requester A request
//   a_ready                  A granted this cycle
//   a_rvalid/a_rdata         A read response (rdata is 0 when rvalid is 0)
//   b_*                      same set of signals for requester B
//   sram_addr/sram_ren/sram_wen/sram_d   SRAM command (all 0 when idle)
//   sram_q                   SRAM read data, valid one cycle after sram_ren
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int MAX_BURST = 4,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic             a_write,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_ready,
  output logic             a_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_valid,
  input  logic             b_write,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_ready,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] b_rdata,
  output logic [AW-1:0]    sram_addr,
  output logic             sram_ren,
  output logic             sram_wen,
  output logic [WIDTH-1:0] sram_d,
  input  logic [WIDTH-1:0] sram_q
);

  // The run counter must be able to hold MAX_BURST itself.
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  req_e             last_r;
  req_e             last_nxt_s;
  logic [CW-1:0]    run_cnt_r;
  logic [CW-1:0]    run_cnt_nxt_s;
  logic             rd_pend_r;
  req_e             rd_id_r;

  logic             grant_raw_s;
  logic             grant_s;
  req_e             winner_s;
  req_e             other_s;
  logic             win_write_s;
  logic [AW-1:0]    win_addr_s;
  logic [WIDTH-1:0] win_wdata_s;

  // Requester that did not win the previous grant; used to hand over the port.
  always_comb begin
    other_s = REQ_A;
    case (last_r)
      REQ_A:   other_s = REQ_B;
      REQ_B:   other_s = REQ_A;
      default: other_s = REQ_A;
    endcase
  end

  // Arbitration: a lone requester always wins; under contention the run limit decides.
  always_comb begin
    grant_raw_s = 1'b0;
    winner_s    = REQ_A;
    case ({a_valid, b_valid})
      2'b10: begin
        grant_raw_s = 1'b1;
        winner_s    = REQ_A;
      end
      2'b01: begin
        grant_raw_s = 1'b1;
        winner_s    = REQ_B;
      end
      2'b11: begin
        grant_raw_s = 1'b1;
        if (run_cnt_r < MAX_CNT) begin
          winner_s = last_r;
        end else begin
          winner_s = other_s;
        end
      end
      default: begin
        grant_raw_s = 1'b0;
        winner_s    = REQ_A;
      end
    endcase
  end

  // Nothing is granted while reset is held, even though the inputs may toggle.
  assign grant_s = grant_raw_s & rst;

  // Select the command fields of the winning requester.
  always_comb begin
    win_write_s = 1'b0;
    win_addr_s  = {AW{1'b0}};
    win_wdata_s = {WIDTH{1'b0}};
    if (winner_s == REQ_B) begin
      win_write_s = b_write;
      win_addr_s  = b_addr;
      win_wdata_s = b_wdata;
    end else begin
      win_write_s = a_write;
      win_addr_s  = a_addr;
      win_wdata_s = a_wdata;
    end
  end

  // SRAM command and grant strobes. The bus is driven to zero on idle cycles.
  always_comb begin
    sram_addr = {AW{1'b0}};
    sram_ren  = 1'b0;
    sram_wen  = 1'b0;
    sram_d    = {WIDTH{1'b0}};
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    if (grant_s) begin
      sram_addr = win_addr_s;
      a_ready   = (winner_s == REQ_A);
      b_ready   = (winner_s == REQ_B);
      if (win_write_s) begin
        sram_wen = 1'b1;
        sram_d   = win_wdata_s;
      end else begin
        sram_ren = 1'b1;
      end
    end else begin
      sram_addr = {AW{1'b0}};
    end
  end

  // Next state for the fairness tracker.
  // The run count saturates at MAX_BURST, so it cannot wrap during a long solo run.
  always_comb begin
    last_nxt_s    = last_r;
    run_cnt_nxt_s = run_cnt_r;
    if (grant_s) begin
      if (winner_s == last_r) begin
        if (run_cnt_r >= MAX_CNT) begin
          run_cnt_nxt_s = MAX_CNT;
        end else begin
          run_cnt_nxt_s = run_cnt_r + ONE_CNT;
        end
      end else begin
        last_nxt_s    = winner_s;
        run_cnt_nxt_s = ONE_CNT;
      end
    end else begin
      run_cnt_nxt_s = ZERO_CNT;
    end
  end

  // Fairness tracker registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_r    <= REQ_A;
      run_cnt_r <= ZERO_CNT;
    end else begin
      last_r    <= last_nxt_s;
      run_cnt_r <= run_cnt_nxt_s;
    end
  end

  // Pending read tracker.
  // Reset clears it, so a read in flight at reset never produces a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_r <= 1'b0;
      rd_id_r   <= REQ_A;
    end else begin
      rd_pend_r <= grant_s & ~win_write_s;
      rd_id_r   <= winner_s;
    end
  end

  // Route the SRAM read data only to the requester that issued the read.
  always_comb begin
    a_rvalid = 1'b0;
    b_rvalid = 1'b0;
    a_rdata  = {WIDTH{1'b0}};
    b_rdata  = {WIDTH{1'b0}};
    if (rd_pend_r) begin
      if (rd_id_r == REQ_B) begin
        b_rvalid = 1'b1;
        b_rdata  = sram_q;
      end else begin
        a_rvalid = 1'b1;
        a_rdata  = sram_q;
      end
    end else begin
      a_rvalid = 1'b0;
      b_rvalid = 1'b0;
    end
  end

  sram_port_arbiter_chk u_chk (
    .clk      (clk),
    .a_valid  (a_valid),
    .b_valid  (b_valid),
    .a_ready  (a_ready),
    .b_ready  (b_ready),
    .a_rvalid (a_rvalid),
    .b_rvalid (b_rvalid),
    .sram_ren (sram_ren),
    .sram_wen (sram_wen)
  );

endmodule

// -----------------------------------------------------------------------------
// sram_port_arbiter_chk
//
// Protocol properties of the arbiter. It has no outputs.
// Ports: clk, the request valids, the grant strobes, the response valids and
// the SRAM strobes.
// -----------------------------------------------------------------------------
module sram_port_arbiter_chk (
  input logic clk,
  input logic a_valid,
  input logic b_valid,
  input logic a_ready,
  input logic b_ready,
  input logic a_rvalid,
  input logic b_rvalid,
  input logic sram_ren,
  input logic sram_wen
);

  // At most one grant per cycle.
  ready_onehot: assert property (@(posedge clk) !(a_ready && b_ready));

  // The SRAM never sees a read and a write together.
  strobe_onehot: assert property (@(posedge clk) !(sram_ren && sram_wen));

  // A read response goes to one requester only.
  rvalid_onehot: assert property (@(posedge clk) !(a_rvalid && b_rvalid));

  // A grant only answers a live request.
  ready_needs_valid: assert property (@(posedge clk)
    (!a_ready || a_valid) && (!b_ready || b_valid));

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Main DUT, MAX_BURST = 4
  logic        a_valid, a_write, b_valid, b_write;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_ready, a_rvalid, b_ready, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic [4:0]  sram_addr;
  logic        sram_ren, sram_wen;
  logic [31:0] sram_d, sram_q;

  // Second DUT, MAX_BURST = 1
  logic        a2_valid, b2_valid;
  logic        a2_ready, a2_rvalid, b2_ready, b2_rvalid;
  logic [31:0] a2_rdata, b2_rdata, s2_d;
  logic [4:0]  s2_addr;
  logic        s2_ren, s2_wen;

  // SRAM model
  logic [31:0] mem [0:31];
  logic [31:0] wr_flag;

  always #5 clk = ~clk;

  sram_port_arbiter #(.WIDTH(32), .DEPTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_addr(sram_addr), .sram_ren(sram_ren), .sram_wen(sram_wen),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  sram_port_arbiter #(.WIDTH(32), .DEPTH(32), .MAX_BURST(1)) dut2 (
    .clk(clk), .rst(rst),
    .a_valid(a2_valid), .a_write(1'b1), .a_addr(5'd0), .a_wdata(32'h0000_0001),
    .a_ready(a2_ready), .a_rvalid(a2_rvalid), .a_rdata(a2_rdata),
    .b_valid(b2_valid), .b_write(1'b1), .b_addr(5'd1), .b_wdata(32'h0000_0002),
    .b_ready(b2_ready), .b_rvalid(b2_rvalid), .b_rdata(b2_rdata),
    .sram_addr(s2_addr), .sram_ren(s2_ren), .sram_wen(s2_wen),
    .sram_d(s2_d), .sram_q(32'h0)
  );

  // Single-port SRAM with 1-cycle read latency.
  // An unwritten word reads as 0xA0000000 | addr.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_flag <= 32'h0;
      sram_q  <= 32'h0;
    end else begin
      if (sram_wen) begin
        mem[sram_addr]     <= sram_d;
        wr_flag[sram_addr] <= 1'b1;
      end
      if (sram_ren) begin
        sram_q <= wr_flag[sram_addr] ? mem[sram_addr] : (32'hA000_0000 | {27'd0, sram_addr});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_write = 1'b0; a_addr = 5'd0; a_wdata = 32'h0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = 5'd0; b_wdata = 32'h0;
    a2_valid = 1'b0; b2_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    step();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      a_valid = i[0]; b_valid = i[1]; a_write = i[2]; b_write = 1'b0;
      a_addr = 5'd7; b_addr = 5'd9; a_wdata = 32'h1234_5678; b_wdata = 32'h9ABC_DEF0;
      a2_valid = i[0]; b2_valid = i[1];
      @(negedge clk);
      checks++;
      if ({a_ready, b_ready, a_rvalid, b_rvalid, sram_ren, sram_wen, a2_ready, b2_ready} !== 8'h00) begin
        errors++;
        $display("FAIL reset_strobes cyc %0d: got %b expected 00000000", i,
                 {a_ready, b_ready, a_rvalid, b_rvalid, sram_ren, sram_wen, a2_ready, b2_ready});
      end
      checks++;
      if ({sram_addr, sram_d, a_rdata, b_rdata} !== 101'd0) begin
        errors++;
        $display("FAIL reset_data cyc %0d: addr=%h d=%h ardata=%h brdata=%h expected all 0",
                 i, sram_addr, sram_d, a_rdata, b_rdata);
      end
    end
    step();
    idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_b2b_reads();
    for (int i = 0; i < 10; i++) begin
      step();
      idle_inputs();
      if (i < 8) begin
        b_valid = 1'b1; b_write = 1'b0; b_addr = 5'(i);
      end
      @(negedge clk);
      if (i < 8) begin
        checks++;
        if ({a_ready, b_ready, sram_ren, sram_wen} !== 4'b0110 || sram_addr !== 5'(i)) begin
          errors++;
          $display("FAIL b2b_grant cyc %0d: rdy/ren/wen=%b addr=%0d expected 0110 addr %0d",
                   i, {a_ready, b_ready, sram_ren, sram_wen}, sram_addr, i);
        end
      end
      if (i >= 1 && i <= 8) begin
        checks++;
        if ({a_rvalid, b_rvalid} !== 2'b01 || b_rdata !== (32'hA000_0000 + 32'(i - 1))) begin
          errors++;
          $display("FAIL b2b_resp cyc %0d: rvalid=%b rdata=%h expected 01 %h",
                   i, {a_rvalid, b_rvalid}, b_rdata, 32'hA000_0000 + 32'(i - 1));
        end
      end
      if (i == 9) begin
        checks++;
        if ({a_rvalid, b_rvalid} !== 2'b00 || b_rdata !== 32'h0) begin
          errors++;
          $display("FAIL b2b_tail: rvalid=%b rdata=%h expected 00 0", {a_rvalid, b_rvalid}, b_rdata);
        end
      end
    end
  endtask

  task automatic test_write_read();
    step();
    idle_inputs();
    a_valid = 1'b1; a_write = 1'b1; a_addr = 5'd3; a_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({a_ready, b_ready, sram_wen, sram_ren, a_rvalid} !== 5'b10100 || sram_addr !== 5'd3
        || sram_d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_cmd: rdy/wen/ren/arv=%b addr=%0d d=%h expected 10100 3 deadbeef",
               {a_ready, b_ready, sram_wen, sram_ren, a_rvalid}, sram_addr, sram_d);
    end
    step();
    idle_inputs();
    b_valid = 1'b1; b_write = 1'b0; b_addr = 5'd3;
    @(negedge clk);
    checks++;
    if ({a_ready, b_ready, sram_ren, sram_wen, a_rvalid, b_rvalid} !== 6'b011000 || sram_addr !== 5'd3) begin
      errors++;
      $display("FAIL rd_cmd: rdy/ren/wen/rv=%b addr=%0d expected 011000 3",
               {a_ready, b_ready, sram_ren, sram_wen, a_rvalid, b_rvalid}, sram_addr);
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b01 || b_rdata !== 32'hDEAD_BEEF || a_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rd_resp: rvalid=%b brdata=%h ardata=%h expected 01 deadbeef 0",
               {a_rvalid, b_rvalid}, b_rdata, a_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rd_single: rvalid=%b expected 00", {a_rvalid, b_rvalid});
    end
  endtask

  task automatic test_burst();
    logic [1:0] exp;
    reset_pulse();
    for (int i = 0; i < 12; i++) begin
      step();
      a_valid = 1'b1; a_write = 1'b1; a_addr = 5'd10; a_wdata = 32'hAAAA_0000 + 32'(i);
      b_valid = 1'b1; b_write = 1'b1; b_addr = 5'd11; b_wdata = 32'hBBBB_0000 + 32'(i);
      exp = (((i / 4) % 2) == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++;
      if ({a_ready, b_ready} !== exp || sram_wen !== 1'b1
          || sram_addr !== ((exp == 2'b10) ? 5'd10 : 5'd11)) begin
        errors++;
        $display("FAIL burst4 cyc %0d: ready=%b wen=%b addr=%0d expected %b 1",
                 i, {a_ready, b_ready}, sram_wen, sram_addr, exp);
      end
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp;
    reset_pulse();
    for (int i = 0; i < 6; i++) begin
      step();
      a2_valid = 1'b1; b2_valid = 1'b1;
      exp = ((i % 2) == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++;
      if ({a2_ready, b2_ready} !== exp || s2_wen !== 1'b1) begin
        errors++;
        $display("FAIL burst1 cyc %0d: ready=%b wen=%b expected %b 1", i, {a2_ready, b2_ready}, s2_wen, exp);
      end
    end
  endtask

  task automatic test_idle_clears_run();
    logic [15:0] vin;
    logic [15:0] vexp;
    // Per cycle {a_valid,b_valid}: A, A, idle, both x5. An idle cycle resets the run.
    vin  = 16'b10_10_00_11_11_11_11_11;
    vexp = 16'b10_10_00_10_10_10_10_01;
    reset_pulse();
    for (int i = 0; i < 8; i++) begin
      step();
      idle_inputs();
      a_write = 1'b1; b_write = 1'b1;
      a_valid = vin[15 - 2*i];
      b_valid = vin[14 - 2*i];
      @(negedge clk);
      checks++;
      if ({a_ready, b_ready} !== vexp[15 - 2*i -: 2]) begin
        errors++;
        $display("FAIL idle_run cyc %0d: ready=%b expected %b", i, {a_ready, b_ready}, vexp[15 - 2*i -: 2]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp;
    reset_pulse();
    for (int i = 0; i < 10; i++) begin
      step();
      idle_inputs();
      a_write = 1'b1; b_write = 1'b1;
      a_valid = 1'b1;
      b_valid = (i >= 8);
      exp = (i < 8) ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++;
      if ({a_ready, b_ready} !== exp) begin
        errors++;
        $display("FAIL saturate cyc %0d: ready=%b expected %b", i, {a_ready, b_ready}, exp);
      end
    end
  endtask

  task automatic test_reset_drop();
    reset_pulse();
    step();
    idle_inputs();
    a_valid = 1'b1; a_write = 1'b0; a_addr = 5'd5;
    @(negedge clk);
    checks++;
    if ({a_ready, sram_ren} !== 2'b11) begin
      errors++;
      $display("FAIL drop_grant: ready/ren=%b expected 11", {a_ready, sram_ren});
    end
    step();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00 || a_rdata !== 32'h0) begin
      errors++;
      $display("FAIL drop_in_reset: rvalid=%b ardata=%h expected 00 0", {a_rvalid, b_rvalid}, a_rdata);
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL drop_after_release: rvalid=%b expected 00", {a_rvalid, b_rvalid});
    end
    step();
    a_valid = 1'b1; a_write = 1'b1; a_addr = 5'd20;
    b_valid = 1'b1; b_write = 1'b1; b_addr = 5'd21;
    @(negedge clk);
    checks++;
    if ({a_ready, b_ready} !== 2'b10 || sram_addr !== 5'd20 || a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL drop_first_contention: ready=%b addr=%0d arvalid=%b expected 10 20 0",
               {a_ready, b_ready}, sram_addr, a_rvalid);
    end
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_b2b_reads();
    test_write_read();
    test_burst();
    test_alternate();
    test_idle_clears_run();
    test_saturation();
    test_reset_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter DEPTH, default 32: SRAM word count; AW = ceil(log2(DEPTH)) is the address width.
REQ-003 Parameter MAX_BURST, default 4: max consecutive grants to one requester under contention; legal range >= 1.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (0 = in reset).
REQ-006 a_valid  in  1  requester A has a request.
REQ-007 a_write  in  1  request A: 1 = write, 0 = read.
REQ-008 a_addr  in  AW  request A word address.
REQ-009 a_wdata  in  WIDTH  request A write data.
REQ-010 a_ready  out  1  request A accepted this cycle.
REQ-011 a_rvalid  out  1  read data for A valid this cycle.
REQ-012 a_rdata  out  WIDTH  read data for A.
REQ-013 b_valid, b_write, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: same directions, widths and meanings as REQ-006..012, for requester B.
REQ-014 sram_addr  out  AW  address to single_port_sram.
REQ-015 sram_ren  out  1  read enable to SRAM.
REQ-016 sram_wen  out  1  write enable to SRAM.
REQ-017 sram_d  out  WIDTH  write data to SRAM.
REQ-018 sram_q  in  WIDTH  SRAM read data, valid one cycle after sram_ren.

Function
REQ-019 Grant is combinational: x_ready = 1 in the same cycle as x_valid when x wins arbitration; a transfer occurs when x_valid & x_ready.
REQ-020 At most one of a_ready, b_ready is 1 per cycle; at most one of sram_ren, sram_wen is 1 per cycle, never both.
REQ-021 Grant cycle: sram_addr = winner addr; winner write -> sram_wen=1, sram_d = winner wdata; winner read -> sram_ren=1.
REQ-022 No-grant cycle: sram_ren = sram_wen = 0, sram_addr = 0, sram_d = 0.
REQ-023 Only one requester valid: that requester is granted unconditionally.
REQ-024 State: last (1 bit, last granted requester, 0=A) and run_cnt (consecutive grants to last, 0..MAX_BURST).
REQ-025 Both valid: grant last if run_cnt < MAX_BURST, else grant the other requester.
REQ-026 After a grant to X: if X == last, run_cnt = min(run_cnt+1, MAX_BURST); else last = X, run_cnt = 1.
REQ-027 Cycle with no grant: run_cnt = 0, last unchanged.
REQ-028 Read latency is exactly 1 cycle: a read granted in cycle t gives x_rvalid = 1 and x_rdata = sram_q in cycle t+1, via registered rd_pend/rd_id.
REQ-029 x_rvalid is never 1 for the requester that did not issue the read; x_rdata = 0 whenever x_rvalid = 0.
REQ-030 No response backpressure; back-to-back reads yield back-to-back rvalid pulses.
REQ-031 Writes produce no response; a write followed by a read of the same address in the next cycle returns the new data.
REQ-032 Addresses pass through unmodified; no range checking.

Reset
REQ-033 While rst = 0: last = A, run_cnt = 0, rd_pend = 0, independent of clk.
REQ-034 While rst = 0: all ready, rvalid, sram_ren and sram_wen outputs = 0; rdata, sram_addr and sram_d = 0.
REQ-035 Reset asserted with a read pending drops that response; no rvalid is issued after rst returns to 1.
REQ-036 First contention after reset is won by A.

Verification
REQ-037 Hold rst=0 while toggling a_valid/b_valid -> all ready/rvalid/ren/wen stay 0.
REQ-038 A writes addr 3 = 0xDEADBEEF, next cycle B reads addr 3 -> b_ready=1 same cycle; b_rvalid=1, b_rdata=0xDEADBEEF one cycle later; a_rvalid=0 throughout.
REQ-039 MAX_BURST=4, A and B valid every cycle from reset -> grant order A,A,A,A,B,B,B,B,A,... with one grant per cycle.
REQ-040 MAX_BURST=1, both valid continuously -> strict alternation A,B,A,B.
REQ-041 B issues reads to addr 0..7 back-to-back, A idle -> b_ready=1 every cycle; b_rvalid=1 for 8 consecutive cycles, data in address order.
REQ-042 A read granted, rst pulsed low in the following cycle -> a_rvalid stays 0; after release, first contention is won by A.
